// File: rtl/motor_pkg.sv
// Shared definitions for the crane-axis motor PWM path.
package motor_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DEADTIME} motor_pwm_state_t;

    localparam int MOTOR_CNT_WIDTH    = 16;
    localparam int MOTOR_DEADTIME_CYC = 100;

endpackage

// File: rtl/motor_pwm_gen.sv
// EN/DIR generator for one PMOD H-bridge: glitch-free PWM with period-boundary
// updates and a forced-low dead time around every direction reversal.
module motor_pwm_gen
    import motor_pkg::*;
#(
    parameter int CNT_WIDTH    = MOTOR_CNT_WIDTH,
    parameter int DEADTIME_CYC = MOTOR_DEADTIME_CYC
) (
    input  logic                 ACLK,
    input  logic                 ARESETN,
    input  logic                 enable,
    input  logic                 dir,
    input  logic [CNT_WIDTH-1:0] period,
    input  logic [CNT_WIDTH-1:0] duty,
    output logic                 pwm_out,
    output logic                 dir_out,
    output logic                 period_tick,
    output logic                 dt_active
);

    localparam int DT_W = (DEADTIME_CYC > 1) ? $clog2(DEADTIME_CYC) : 1;
    localparam logic [DT_W-1:0] DT_LAST = DT_W'(DEADTIME_CYC - 1);

    motor_pwm_state_t     r_state;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] r_period_sh;
    logic [CNT_WIDTH-1:0] r_duty_sh;
    logic                 r_dir_sh;
    logic [DT_W-1:0]      r_dt_cnt;
    logic                 w_boundary;
    logic                 w_dt_done;

    assign w_boundary = (r_cnt == r_period_sh);
    assign w_dt_done  = (r_dt_cnt == DT_LAST);

    // Both counters sit at zero outside their own state, so entry needs no explicit clear.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_cnt    <= '0;
            r_dt_cnt <= '0;
        end else begin
            r_cnt    <= (enable && r_state == RUN && !w_boundary) ?
                        r_cnt + CNT_WIDTH'(1) : '0;
            r_dt_cnt <= (enable && r_state == DEADTIME && !w_dt_done) ?
                        r_dt_cnt + DT_W'(1) : '0;
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_state     <= IDLE;
            r_period_sh <= '0;
            r_duty_sh   <= '0;
            r_dir_sh    <= 1'b0;
            pwm_out     <= 1'b0;
            dir_out     <= 1'b0;
            period_tick <= 1'b0;
            dt_active   <= 1'b0;
        end else if (!enable) begin
            r_state     <= IDLE;
            pwm_out     <= 1'b0;
            period_tick <= 1'b0;
            dt_active   <= 1'b0;
        end else begin
            period_tick <= 1'b0;
            case (r_state)
                IDLE: begin
                    pwm_out     <= 1'b0;
                    r_period_sh <= period;
                    r_duty_sh   <= duty;
                    r_dir_sh    <= dir;
                    if (dir != dir_out) begin
                        r_state   <= DEADTIME;
                        dt_active <= 1'b1;
                    end else begin
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    pwm_out <= (r_cnt < r_duty_sh);
                    if (w_boundary) begin
                        period_tick <= 1'b1;
                        r_period_sh <= period;
                        r_duty_sh   <= duty;
                        r_dir_sh    <= dir;
                        if (dir != dir_out) begin
                            r_state   <= DEADTIME;
                            dt_active <= 1'b1;
                        end
                    end
                end
                DEADTIME: begin
                    // DIR flips only here, one edge before EN may rise again.
                    pwm_out <= 1'b0;
                    if (w_dt_done) begin
                        dir_out   <= r_dir_sh;
                        dt_active <= 1'b0;
                        r_state   <= RUN;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_motor_pwm_gen.sv
// Self-checking bench: expected outputs come from a schedule model that lays out
// whole periods and dead-time windows each time the inputs are sampled.
module tb_motor_pwm_gen;

    localparam int CW = 16;
    localparam int DT = 4;

    logic          ACLK    = 1'b0;
    logic          ARESETN = 1'b0;
    logic          enable  = 1'b0;
    logic          dir     = 1'b0;
    logic [CW-1:0] period  = '0;
    logic [CW-1:0] duty    = '0;
    logic          pwm_out, dir_out, period_tick, dt_active;

    motor_pwm_gen #(.CNT_WIDTH(CW), .DEADTIME_CYC(DT)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .enable(enable), .dir(dir),
        .period(period), .duty(duty), .pwm_out(pwm_out), .dir_out(dir_out),
        .period_tick(period_tick), .dt_active(dt_active)
    );

    always #5 ACLK = ~ACLK;

    // One expected output sample per clock edge; 'last' marks the period end,
    // the edge at which the inputs are sampled again.
    typedef struct packed {
        logic pwm;
        logic tick;
        logic dt;
        logic dir;
        logic last;
    } ent_t;

    ent_t q[$];
    ent_t expv;
    logic m_dir  = 1'b0;
    logic m_idle = 1'b1;
    int   errors = 0;
    int   checks = 0;
    bit   dt_seen;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at %0t: observed=%b expected=%b", tag, $time, obs, exp);
        end
    endtask

    // Inputs sampled now: lay out optional dead time and then one full period.
    task automatic trigger(input logic p, input logic t);
        logic rev;
        rev  = (dir !== m_dir);
        expv = '{pwm: p, tick: t, dt: rev, dir: m_dir, last: 1'b0};
        if (rev) begin
            for (int k = 0; k < DT - 1; k++)
                q.push_back('{pwm: 1'b0, tick: 1'b0, dt: 1'b1, dir: m_dir, last: 1'b0});
            q.push_back('{pwm: 1'b0, tick: 1'b0, dt: 1'b0, dir: dir, last: 1'b0});
        end
        for (int j = 0; j < int'(period); j++)
            q.push_back('{pwm: (j < int'(duty)), tick: 1'b0, dt: 1'b0, dir: dir, last: 1'b0});
        q.push_back('{pwm: (int'(period) < int'(duty)), tick: 1'b1, dt: 1'b0, dir: dir, last: 1'b1});
        m_idle = 1'b0;
    endtask

    task automatic model_edge();
        ent_t h;
        if (!ARESETN) begin
            expv = '0;
            q.delete();
            m_idle = 1'b1;
        end else if (!enable) begin
            expv = '{pwm: 1'b0, tick: 1'b0, dt: 1'b0, dir: m_dir, last: 1'b0};
            q.delete();
            m_idle = 1'b1;
        end else if (m_idle) begin
            trigger(1'b0, 1'b0);
        end else begin
            h = q.pop_front();
            if (h.last) trigger(h.pwm, 1'b1);
            else        expv = h;
        end
        m_dir = expv.dir;
    endtask

    task automatic step();
        model_edge();
        @(posedge ACLK);
        #1;
        chk("pwm_out", pwm_out, expv.pwm);
        chk("dir_out", dir_out, expv.dir);
        chk("period_tick", period_tick, expv.tick);
        chk("dt_active", dt_active, expv.dt);
        if (dt_active === 1'b1) dt_seen = 1'b1;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    initial begin
        int n;
        // reset state
        run(3);
        ARESETN = 1'b1;
        run(2);

        // basic 3 high / 7 low, no reversal
        dt_seen = 1'b0;
        period = 16'd9; duty = 16'd3; dir = 1'b0; enable = 1'b1;
        run(35);
        chk("no_deadtime_when_dir_same", dt_seen, 1'b0);

        // 0% then 100% (duty > period)
        duty = 16'd0;  run(25);
        duty = 16'd12; run(25);

        // mid-period duty change takes effect only at the next boundary
        duty = 16'd3;  run(23);
        duty = 16'd7;  run(25);

        // direction reversal at a boundary
        duty = 16'd3; run(12);
        dt_seen = 1'b0;
        dir = 1'b1;   run(30);
        chk("deadtime_taken_on_reversal", dt_seen, 1'b1);

        // enable dropped while EN high, then re-enable the other way
        n = 0;
        while (pwm_out !== 1'b1 && n < 20) begin step(); n++; end
        chk("wait_pwm_high", pwm_out, 1'b1);
        enable = 1'b0; run(4);
        dir = 1'b0; enable = 1'b1; run(25);

        // reset in the middle of a dead time
        dir = 1'b1;
        n = 0;
        while (dt_active !== 1'b1 && n < 30) begin step(); n++; end
        chk("wait_deadtime", dt_active, 1'b1);
        ARESETN = 1'b0; run(1);
        ARESETN = 1'b1; enable = 1'b0; dir = 1'b0; run(2);

        // period=0: every edge is a boundary
        period = 16'd0; duty = 16'd1; enable = 1'b1;
        run(12);
        chk("period0_tick", period_tick, 1'b1);
        chk("period0_pwm", pwm_out, 1'b1);

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            ARESETN = ($urandom_range(0, 299) != 0);
            if (enable) begin
                if ($urandom_range(0, 39) == 0) enable = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                enable = 1'b1;
            end
            if ($urandom_range(0, 19) == 0) period = CW'($urandom_range(0, 12));
            if ($urandom_range(0, 9) == 0)
                duty = ($urandom_range(0, 7) == 0) ? 16'hFFFF : CW'($urandom_range(0, 15));
            if ($urandom_range(0, 59) == 0) dir = ~dir;
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/motor_pwm_gen.md
# motor_pwm_gen

Converts the motor command registers written over AXI4-Lite (enable, direction, PWM period, PWM duty) into the EN/DIR pin pair driving the PMOD H-bridge of one crane axis. Sits directly downstream of the axi_motor register slave, between its register outputs and the PMOD connector pins. Guarantees glitch-free PWM: new period/duty take effect only at period boundaries. Every direction reversal inserts a dead time with EN held low, so DIR never toggles while the bridge is driven.

## Interface
- CNT_WIDTH, 16: width of period, duty and the period counter.
- DEADTIME_CYC, 100: ACLK cycles EN is forced low around a direction change; must be ≥1.
- ACLK  in  1  system clock.
- ARESETN  in  1  reset, synchronous, active-low.
- enable  in  1  motor enable from the control register.
- dir  in  1  requested direction from the control register.
- period  in  CNT_WIDTH  PWM period minus one, in ACLK cycles.
- duty  in  CNT_WIDTH  high-time in ACLK cycles.
- pwm_out  out  1  H-bridge EN pin.
- dir_out  out  1  H-bridge DIR pin.
- period_tick  out  1  one-cycle pulse at each period wrap.
- dt_active  out  1  high while in dead time.

## Operation
- Reset (ARESETN low at an edge):
  - state=IDLE; cnt, dt_cnt and shadow registers cleared.
  - pwm_out, dir_out, period_tick and dt_active all 0.
- States are IDLE, RUN and DEADTIME.
- IDLE:
  - cnt held at 0; pwm_out 0; dir_out holds its value.
  - On an edge with enable=1: load period_sh, duty_sh and dir_sh from the inputs; cnt←0.
  - Then go to DEADTIME if dir≠dir_out, otherwise to RUN.
- RUN:
  - cnt←(cnt==period_sh) ? 0 : cnt+1.
  - pwm_out←(cnt<duty_sh).
  - At cnt==period_sh (boundary): period_tick←1; reload all three shadows from the inputs.
  - At the boundary, if the new dir_sh≠dir_out, go to DEADTIME.
- DEADTIME:
  - pwm_out 0; dt_active 1; dt_cnt increments from 0.
  - At dt_cnt==DEADTIME_CYC-1: dir_out←dir_sh; cnt←0; dt_active←0; go to RUN.
  - Input changes during DEADTIME are ignored until the next boundary.
- enable=0 sampled in any state: go to IDLE at that edge.
  - pwm_out←0 and dt_active←0 at the same edge.
  - dir_out unchanged.
- Arithmetic is unsigned, CNT_WIDTH bits.
  - duty≥period+1 gives 100% (pwm_out constantly high).
  - duty=0 gives 0%.
  - period=0 is legal: cnt stays 0, every cycle is a boundary, pwm_out=(duty≠0).

## Timing
- pwm_out is registered and lags cnt by one cycle.
- High time per period is min(duty_sh, period_sh+1) cycles; period length is period_sh+1 cycles.
- Enable rise with no direction change: RUN is entered at the edge sampling enable=1. pwm_out first reflects cnt=0 at the following edge, i.e. 2-cycle latency.
- Enable fall: pwm_out low at the first edge sampling enable=0 (1-cycle latency).
- period_tick is high for exactly the cycle after the boundary edge.
- Direction reversal at a boundary:
  - pwm_out low for exactly DEADTIME_CYC cycles.
  - dir_out changes on the edge that exits DEADTIME.
  - pwm_out may rise one edge later at the earliest, so EN and DIR never change on the same edge.
- Register inputs are sampled only at boundaries or on the IDLE→enable edge. Mid-period writes never glitch the current period.
- Reset mid-operation: all outputs 0 at the resetting edge regardless of state.

## Structure
- Shared package motor_pkg holds:
  - typedef enum {IDLE, RUN, DEADTIME} motor_pwm_state_t;
  - localparam defaults MOTOR_CNT_WIDTH=16 and MOTOR_DEADTIME_CYC=100.
- Single module, no sub-module; one counter process, one FSM process, registered outputs.

## Test plan
- period=9, duty=3, dir=0, enable=1 → pwm_out 3 high/7 low repeating; period_tick every 10 cycles; dir_out=0; dt_active never high.
- period=9, duty=0 → pwm_out constantly 0. Then duty=12 → constantly 1 from the next boundary.
- period=9, duty=3, change duty to 7 mid-period (cnt=5) → current period 3 high, next period 7 high; no short or extra pulse.
- DEADTIME_CYC=4, running period=9/duty=3, toggle dir →
  - at the next boundary pwm_out low 4 cycles with dt_active high;
  - dir_out flips on the exit edge;
  - then pwm_out 3 high/7 low again.
- enable dropped while pwm_out high → pwm_out 0 one edge later, dir_out held. Re-enable with the other dir → dead time taken before the first pulse.
- ARESETN low during DEADTIME → all outputs 0 at that edge. Also period=0, duty=1 → pwm_out constantly high and period_tick high every cycle.
